// File: rtl/chess_link_pkg.sv
// Shared types and constants for the inter-board chess link.
//   link_state_e : turn-scheduler states
//   link_word_t  : 8-bit cable word, [7] token, [6] pick, [5:0] square
//   turn_granted : turn rule shared by IDLE entry and REMOTE exit
package chess_link_pkg;

   localparam int unsigned LINK_W       = 8;
   localparam int unsigned LINK_TOK     = 7;
   localparam int unsigned LINK_PICK    = 6;
   localparam int unsigned LINK_POS_MSB = 5;

   typedef logic [LINK_W-1:0] link_word_t;

   typedef enum logic [2:0] {
      IDLE,
      LOCAL,
      HANDOFF,
      REMOTE,
      ERR
   } link_state_e;

   // White owns the turn while both tokens agree, black while they differ.
   function automatic logic turn_granted(input logic white, input logic tx_tog,
                                         input logic rx_tog);
      return white ? (tx_tog == rx_tog) : (tx_tog != rx_tog);
   endfunction

endpackage

// File: rtl/chess_link_rx_filter.sv
// Synchroniser and stability filter for the raw link_in cable word.
//   clk, rst  : clock, async active-low reset
//   link_in   : raw cable word
//   acc_word  : last accepted (stable) word
//   acc_stb   : one-cycle strobe, high in the cycle acc_word takes a new value
module chess_link_rx_filter
   import chess_link_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  link_word_t link_in,
   output link_word_t acc_word,
   output logic       acc_stb
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

   logic [SYNC_STAGES-1:0][LINK_W-1:0] sync_q;
   link_word_t                         sync_w;
   link_word_t                         cand_q;
   link_word_t                         acc_q;
   logic [CW-1:0]                      cnt_q;
   logic [CW-1:0]                      cnt_d;
   logic                               vld_q;
   logic                               stb_q;
   logic                               hit;

   assign sync_w   = link_word_t'(sync_q[SYNC_STAGES-1]);
   assign acc_word = acc_q;
   assign acc_stb  = stb_q;

   // Run length of the current candidate; accept the cycle it reaches
   // STABLE_CYCLES, but only if it is the first word or a new value.
   always_comb begin
      cnt_d = CW'(1);
      if (sync_w == cand_q) begin
         cnt_d = (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + CW'(1);
      end
      hit = (cnt_d == CW'(STABLE_CYCLES)) &&
            ((cnt_q != CW'(STABLE_CYCLES)) || (sync_w != cand_q)) &&
            (!vld_q || (sync_w != acc_q));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         cand_q <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
         stb_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], link_in};
         cand_q <= sync_w;
         cnt_q  <= cnt_d;
         stb_q  <= hit;
         if (hit) begin
            acc_q <= sync_w;
            vld_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/chess_link_ctrl.sv
// Turn scheduler and link controller for the 8-bit inter-board cable.
//   clk, rst     : 75 MHz clock, async active-low reset
//   set_player   : role (1 = white), sampled on first acceptance in IDLE
//   local_pick, local_pos, local_commit : local move events
//   link_in      : raw cable input (filtered internally)
//   link_out     : cable output, [7] token, [6] pick, [5:0] square
//   my_turn      : local board may move
//   opp_valid, opp_pick, opp_pos : accepted remote payload + update pulse
//   link_err     : sticky protocol error
module chess_link_ctrl
   import chess_link_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned SETUP_CYCLES  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_player,
   input  logic                  local_pick,
   input  logic [LINK_POS_MSB:0] local_pos,
   input  logic                  local_commit,
   input  link_word_t            link_in,
   output link_word_t            link_out,
   output logic                  my_turn,
   output logic                  opp_valid,
   output logic                  opp_pick,
   output logic [LINK_POS_MSB:0] opp_pos,
   output logic                  link_err
);

   localparam int unsigned HW = $clog2(SETUP_CYCLES + 1);

   link_word_t            acc_word;
   logic                  acc_stb;
   logic                  rx_tog;
   logic                  rx_chg;

   link_state_e           state_q,    state_d;
   logic                  white_q,    white_d;
   link_word_t            link_q,     link_d;
   logic [HW-1:0]         hcnt_q,     hcnt_d;
   logic                  rx_tog_q;
   logic                  rx_moved_q, rx_moved_d;
   logic                  turn_q,     turn_d;
   logic                  ovld_q,     ovld_d;
   logic                  opick_q,    opick_d;
   logic [LINK_POS_MSB:0] opos_q,     opos_d;
   logic                  err_q,      err_d;

   chess_link_rx_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_rx_filter (
      .clk      (clk),
      .rst      (rst),
      .link_in  (link_in),
      .acc_word (acc_word),
      .acc_stb  (acc_stb)
   );

   assign rx_tog    = acc_word[LINK_TOK];
   assign rx_chg    = rx_tog != rx_tog_q;
   assign link_out  = link_q;
   assign my_turn   = turn_q;
   assign opp_valid = ovld_q;
   assign opp_pick  = opick_q;
   assign opp_pos   = opos_q;
   assign link_err  = err_q;

   // Next-state and next-output logic; an illegal token change wins over commit.
   always_comb begin
      state_d    = state_q;
      white_d    = white_q;
      link_d     = link_q;
      hcnt_d     = hcnt_q;
      rx_moved_d = rx_moved_q;
      ovld_d     = 1'b0;
      opick_d    = opick_q;
      opos_d     = opos_q;

      case (state_q)
         IDLE: begin
            if (acc_stb) begin
               white_d    = set_player;
               rx_moved_d = 1'b0;
               state_d    = turn_granted(set_player, link_q[LINK_TOK], rx_tog) ? LOCAL : REMOTE;
            end
         end
         LOCAL: begin
            if (rx_chg) begin
               state_d = ERR;
            end else begin
               link_d[LINK_PICK:0] = {local_pick, local_pos};
               if (local_commit) begin
                  hcnt_d  = '0;
                  state_d = HANDOFF;
               end
            end
         end
         HANDOFF: begin
            if (rx_chg) begin
               state_d = ERR;
            end else if (hcnt_q == HW'(SETUP_CYCLES - 1)) begin
               link_d[LINK_TOK] = ~link_q[LINK_TOK];
               rx_moved_d       = 1'b0;
               state_d          = REMOTE;
            end else begin
               hcnt_d = hcnt_q + HW'(1);
            end
         end
         REMOTE: begin
            if (rx_chg && rx_moved_q) begin
               state_d = ERR;
            end else begin
               if (rx_chg) begin
                  rx_moved_d = 1'b1;
               end
               if (acc_stb && (acc_word[LINK_PICK:0] != {opick_q, opos_q})) begin
                  opick_d = acc_word[LINK_PICK];
                  opos_d  = acc_word[LINK_POS_MSB:0];
                  ovld_d  = 1'b1;
               end
               if (turn_granted(white_q, link_q[LINK_TOK], rx_tog)) begin
                  state_d = LOCAL;
               end
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      turn_d = (state_d == LOCAL);
      err_d  = (state_d == ERR);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         white_q    <= 1'b0;
         link_q     <= '0;
         hcnt_q     <= '0;
         rx_tog_q   <= 1'b0;
         rx_moved_q <= 1'b0;
         turn_q     <= 1'b0;
         ovld_q     <= 1'b0;
         opick_q    <= 1'b0;
         opos_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         white_q    <= white_d;
         link_q     <= link_d;
         hcnt_q     <= hcnt_d;
         rx_tog_q   <= rx_tog;
         rx_moved_q <= rx_moved_d;
         turn_q     <= turn_d;
         ovld_q     <= ovld_d;
         opick_q    <= opick_d;
         opos_q     <= opos_d;
         err_q      <= err_d;
      end
   end

endmodule
